// File: rtl/cc_pkg.sv
// Shared definitions for the cache-controller miss path: AXI AR encodings,
// line geometry, address field positions and the miss-request FSM states.
package cc_pkg;

    // AXI read-address channel encodings used for line fills
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

    // A line is 8 beats of 64 bits; ARLEN is beats-1
    localparam int         LINE_BEATS = 8;
    localparam logic [3:0] CC_ARLEN   = 4'd7;

    // Byte-address field positions as seen by the fill unit
    localparam int TAG_MSB    = 31;
    localparam int TAG_LSB    = 15;
    localparam int INDEX_MSB  = 14;
    localparam int INDEX_LSB  = 6;
    localparam int OFFSET_MSB = 5;
    localparam int OFFSET_LSB = 0;
    localparam int BEAT_LSB   = 3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_AR   = 1'b1
    } miss_state_t;

    // Align a byte address to its 64-bit beat (critical word first start)
    function automatic logic [31:0] beat_align(input logic [31:0] addr);
        return {addr[31:BEAT_LSB], 3'b000};
    endfunction

endpackage

// File: rtl/cc_miss_req_ctrl.sv
// Miss request controller: accepts a line miss, pushes its address into the
// miss address FIFO, issues a critical-word-first WRAP8 AXI read burst and
// tracks outstanding fills so the front end can be stalled.
module cc_miss_req_ctrl
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 1,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req_i,
    input  logic [31:0]      miss_addr_i,
    output logic             miss_ack_o,
    output logic             miss_busy_o,
    output logic             mem_arvalid_o,
    input  logic             mem_arready_i,
    output logic [31:0]      mem_araddr_o,
    output logic [3:0]       mem_arlen_o,
    output logic [2:0]       mem_arsize_o,
    output logic [1:0]       mem_arburst_o,
    input  logic             miss_addr_fifo_full_i,
    output logic             miss_addr_fifo_wren_o,
    output logic [31:0]      miss_addr_fifo_wdata_o,
    input  logic             fill_done_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o,
    output logic [31:0]      miss_cnt_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    miss_state_t      state_r;
    logic [31:0]      addr_r;
    logic [CNT_W-1:0] outstanding_r;
    logic             err_r;
    logic [31:0]      miss_cnt_r;

    logic accept_s;
    logic ar_hs_s;
    logic in_ar_s;

    assign in_ar_s  = (state_r == S_AR);
    assign accept_s = (state_r == S_IDLE) & miss_req_i & ~miss_addr_fifo_full_i
                      & (outstanding_r < MAX_CNT);
    assign ar_hs_s  = in_ar_s & mem_arready_i;

    // FSM: latch the miss address on accept, hold it until the AR handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            addr_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r <= S_AR;
                        addr_r  <= miss_addr_i;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (mem_arready_i) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_AR;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Outstanding-fill counter plus sticky underflow error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= CNT_ZERO;
            err_r         <= 1'b0;
        end else begin
            case ({ar_hs_s, fill_done_i})
                2'b10: begin
                    outstanding_r <= outstanding_r + CNT_ONE;
                end
                2'b01: begin
                    if (outstanding_r == CNT_ZERO) begin
                        err_r <= 1'b1;
                    end else begin
                        outstanding_r <= outstanding_r - CNT_ONE;
                    end
                end
                default: begin
                    outstanding_r <= outstanding_r;
                end
            endcase
        end
    end

    // Saturating count of accepted misses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_r <= 32'h0000_0000;
        end else if (accept_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
            miss_cnt_r <= miss_cnt_r + 32'd1;
        end else begin
            miss_cnt_r <= miss_cnt_r;
        end
    end

    // AR channel fields: only driven while a request is presented
    always_comb begin
        mem_arvalid_o = 1'b0;
        mem_araddr_o  = 32'h0000_0000;
        mem_arlen_o   = 4'd0;
        mem_arsize_o  = 3'd0;
        mem_arburst_o = 2'b00;
        if (in_ar_s) begin
            mem_arvalid_o = 1'b1;
            mem_araddr_o  = beat_align(addr_r);
            mem_arlen_o   = CC_ARLEN;
            mem_arsize_o  = AXI_SIZE_8B;
            mem_arburst_o = AXI_BURST_WRAP;
        end else begin
            mem_arvalid_o = 1'b0;
        end
    end

    // Same-cycle acceptance: ack and FIFO push carry the full miss address
    always_comb begin
        miss_ack_o             = 1'b0;
        miss_addr_fifo_wren_o  = 1'b0;
        miss_addr_fifo_wdata_o = 32'h0000_0000;
        if (accept_s) begin
            miss_ack_o             = 1'b1;
            miss_addr_fifo_wren_o  = 1'b1;
            miss_addr_fifo_wdata_o = miss_addr_i;
        end else begin
            miss_ack_o = 1'b0;
        end
    end

    // Front-end stall from registered state and FIFO status only
    assign miss_busy_o   = in_ar_s | (outstanding_r == MAX_CNT) | miss_addr_fifo_full_i;
    assign outstanding_o = outstanding_r;
    assign err_o         = err_r;
    assign miss_cnt_o    = miss_cnt_r;

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Self-checking bench for cc_miss_req_ctrl (MAX_OUTSTANDING=2).
module tb_cc_miss_req_ctrl;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        ack, busy, arvalid, arready, full, wren, fill, err;
    logic [31:0] araddr, wdata, miss_cnt;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    // Reference model: pending AR flag/address, outstanding fills, error, count
    bit          m_ar;
    logic [31:0] m_addr;
    int          m_out;
    bit          m_err;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    cc_miss_req_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req_i(miss_req), .miss_addr_i(miss_addr),
        .miss_ack_o(ack), .miss_busy_o(busy),
        .mem_arvalid_o(arvalid), .mem_arready_i(arready),
        .mem_araddr_o(araddr), .mem_arlen_o(arlen),
        .mem_arsize_o(arsize), .mem_arburst_o(arburst),
        .miss_addr_fifo_full_i(full),
        .miss_addr_fifo_wren_o(wren), .miss_addr_fifo_wdata_o(wdata),
        .fill_done_i(fill), .outstanding_o(outstanding),
        .err_o(err), .miss_cnt_o(miss_cnt)
    );

    function automatic bit exp_acc();
        return !m_ar && miss_req && !full && (m_out < MAXO);
    endfunction

    function automatic bit exp_busy();
        return m_ar || (m_out == MAXO) || full;
    endfunction

    task automatic model_reset();
        m_ar = 1'b0; m_addr = 32'h0; m_out = 0; m_err = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_update();
        bit acc, hs;
        int inc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = exp_acc();
        hs  = m_ar && arready;
        inc = hs ? 1 : 0;
        if (fill && m_out == 0 && !hs) m_err = 1'b1;
        m_out = m_out + inc - ((fill && (m_out + inc) > 0) ? 1 : 0);
        if (acc) begin
            m_ar = 1'b1;
            m_addr = miss_addr;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end else if (hs) begin
            m_ar = 1'b0;
        end
    endtask

    // Advance one clock: model follows the DUT's edge, return at negedge
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_out > 0; i++) begin
            miss_req = 1'b0; fill = 1'b1; #1; tick();
        end
        fill = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = 32'h0; arready = 1'b0;
        full = 1'b0; fill = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({arvalid, wren, ack, busy, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {arvalid, wren, ack, busy, err});
        end
        checks++;
        if (outstanding !== 3'd0 || miss_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_counts got out=%0d cnt=%0d want 0 0", outstanding, miss_cnt);
        end
        checks++;
        if (araddr !== 32'd0 || wdata !== 32'd0) begin
            errors++; $display("FAIL reset_data got araddr=%h wdata=%h want 0 0", araddr, wdata);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_miss();
        miss_req = 1'b1; miss_addr = 32'h0001_2368; arready = 1'b1; full = 1'b0; fill = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b1 || wren !== 1'b1 || wdata !== 32'h0001_2368) begin
            errors++; $display("FAIL single_accept got ack=%b wren=%b wdata=%h want 1 1 00012368", ack, wren, wdata);
        end
        tick();
        miss_req = 1'b0; miss_addr = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h0001_2368) begin
            errors++; $display("FAIL single_ar got arvalid=%b araddr=%h want 1 00012368", arvalid, araddr);
        end
        checks++;
        if ({arlen, arsize, arburst} !== {4'd7, 3'd3, 2'd2} || busy !== 1'b1 || ack !== 1'b0) begin
            errors++; $display("FAIL single_arfields got len=%0d size=%0d burst=%0d busy=%b ack=%b want 7 3 2 1 0",
                               arlen, arsize, arburst, busy, ack);
        end
        tick();
        #1;
        checks++;
        if (outstanding !== 3'd1 || arvalid !== 1'b0 || busy !== exp_busy()) begin
            errors++; $display("FAIL single_issued got out=%0d arvalid=%b busy=%b want 1 0 %b",
                               outstanding, arvalid, busy, exp_busy());
        end
        fill = 1'b1; #1; tick(); fill = 1'b0; #1;
        checks++;
        if (outstanding !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL single_fill got out=%0d busy=%b err=%b want 0 0 0", outstanding, busy, err);
        end
    endtask

    task automatic test_ar_backpressure();
        logic [31:0] a;
        int hs = 0, vcyc = 0;
        a = {$urandom} & 32'hFFFF_FFF8;
        miss_req = 1'b1; miss_addr = a; arready = 1'b0; #1; tick();
        miss_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            arready = (i == 5); #1;
            if (arvalid === 1'b1) vcyc++;
            checks++;
            if (arvalid !== 1'b1 || araddr !== a) begin
                errors++; $display("FAIL bp_stable cyc %0d got arvalid=%b araddr=%h want 1 %h", i, arvalid, araddr, a);
            end
            if (arvalid && arready) hs++;
            tick();
        end
        arready = 1'b1; #1;
        checks++;
        if (hs != 1 || vcyc != 6 || arvalid !== 1'b0 || outstanding !== 3'd1) begin
            errors++; $display("FAIL bp_handshake got hs=%0d vcyc=%0d arvalid=%b out=%0d want 1 6 0 1",
                               hs, vcyc, arvalid, outstanding);
        end
        drain();
    endtask

    task automatic test_fifo_full();
        miss_req = 1'b1; miss_addr = 32'h0BAD_0040; arready = 1'b1; full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ack !== 1'b0 || wren !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL full_block cyc %0d got ack=%b wren=%b busy=%b want 0 0 1", i, ack, wren, busy);
            end
            tick();
        end
        full = 1'b0; #1;
        checks++;
        if (ack !== 1'b1 || wren !== 1'b1 || wdata !== 32'h0BAD_0040) begin
            errors++; $display("FAIL full_release got ack=%b wren=%b wdata=%h want 1 1 0bad0040", ack, wren, wdata);
        end
        tick(); miss_req = 1'b0; #1; tick(); drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        int acks [$];
        int idx = 0;
        for (int k = 0; k < 3; k++) addrs[k] = {$urandom} & 32'hFFFF_FFC0;
        arready = 1'b1; full = 1'b0;
        for (int c = 0; c < 7; c++) begin
            miss_req = (idx < 3); miss_addr = addrs[idx < 3 ? idx : 2];
            fill = (c == 5);
            #1;
            if (ack === 1'b1) begin acks.push_back(c); idx++; end
            if (c == 4) begin
                checks++;
                if (outstanding !== 3'd2 || busy !== 1'b1 || ack !== 1'b0) begin
                    errors++; $display("FAIL b2b_full got out=%0d busy=%b ack=%b want 2 1 0", outstanding, busy, ack);
                end
            end
            if (c == 6) begin
                checks++;
                if (outstanding !== 3'd1 || ack !== 1'b1 || wdata !== addrs[2]) begin
                    errors++; $display("FAIL b2b_third got out=%0d ack=%b wdata=%h want 1 1 %h", outstanding, ack, wdata, addrs[2]);
                end
            end
            tick();
        end
        miss_req = 1'b0; fill = 1'b0;
        checks++;
        if (acks.size() != 3 || acks[0] != 0 || acks[1] != 2 || acks[2] != 6) begin
            errors++; $display("FAIL b2b_ackcycles got n=%0d first=%0d want 3 acks at 0 2 6", acks.size(),
                               acks.size() > 0 ? acks[0] : -1);
        end
        #1; tick(); drain();
    endtask

    task automatic test_simultaneous();
        arready = 1'b1; full = 1'b0;
        miss_req = 1'b1; miss_addr = 32'h0000_1000; #1; tick();
        miss_req = 1'b0; #1; tick();
        miss_req = 1'b1; miss_addr = 32'h0000_2000; #1; tick();
        miss_req = 1'b0; fill = 1'b1; #1; tick();
        fill = 1'b0; #1;
        checks++;
        if (outstanding !== 3'd1 || err !== 1'b0) begin
            errors++; $display("FAIL simul_hs_fill got out=%0d err=%b want 1 0", outstanding, err);
        end
        fill = 1'b1; #1; tick(); #1; tick(); fill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (err !== 1'b1 || outstanding !== 3'd0) begin
                errors++; $display("FAIL err_sticky cyc %0d got err=%b out=%0d want 1 0", i, err, outstanding);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        arready = 1'b1; full = 1'b0;
        miss_req = 1'b1; miss_addr = 32'h0000_3000; #1; tick();
        miss_req = 1'b0; #1; tick();
        arready = 1'b0; miss_req = 1'b1; miss_addr = 32'h0000_4000; #1; tick();
        miss_req = 1'b0; #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b0 || outstanding !== 3'd0 || err !== 1'b0 || miss_cnt !== 32'd0) begin
            errors++; $display("FAIL async_reset got arvalid=%b out=%0d err=%b cnt=%0d want 0 0 0 0",
                               arvalid, outstanding, err, miss_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; arready = 1'b1;
        @(negedge clk);
        test_single_miss();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            miss_req  = ($urandom_range(0, 3) != 0);
            miss_addr = $urandom;
            arready   = $urandom_range(0, 1);
            full      = ($urandom_range(0, 5) == 0);
            fill      = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if ({ack, wren, arvalid, busy, err} !== {exp_acc(), exp_acc(), m_ar, exp_busy(), m_err}) begin
                errors++; $display("FAIL rand_flags cyc %0d got %b want %b", c, {ack, wren, arvalid, busy, err},
                                   {exp_acc(), exp_acc(), m_ar, exp_busy(), m_err});
            end
            checks++;
            if (outstanding !== 3'(m_out) || miss_cnt !== m_cnt) begin
                errors++; $display("FAIL rand_counts cyc %0d got out=%0d cnt=%0d want %0d %0d", c, outstanding, miss_cnt, m_out, m_cnt);
            end
            if (exp_acc()) begin
                checks++;
                if (wdata !== miss_addr) begin
                    errors++; $display("FAIL rand_wdata cyc %0d got %h want %h", c, wdata, miss_addr);
                end
            end
            if (m_ar) begin
                checks++;
                if (araddr !== (m_addr & 32'hFFFF_FFF8) || {arlen, arsize, arburst} !== {4'd7, 3'd3, 2'd2}) begin
                    errors++; $display("FAIL rand_ar cyc %0d got %h/%0d/%0d/%0d want %h/7/3/2", c, araddr, arlen, arsize,
                                       arburst, m_addr & 32'hFFFF_FFF8);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_ar_backpressure();
        test_fifo_full();
        test_back_to_back();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
